bvudiv_seq: RTL and testbench

Sequential unsigned bit-vector divider with SMT-LIB `bvudiv`/`bvurem` semantics, including the divide-by-zero convention: quotient all ones, remainder equal to the dividend. It sits directly upstream of the `bvudiv` Skolem/invariant checkers. It produces the quotient, remainder and zero-divisor flag that those combinational predicates consume. It uses a restoring radix-2 algorithm, one quotient bit per cycle, with a valid/ready handshake on both sides.

---
 rtl/bvudiv_pkg.sv | 21 ++
 rtl/bvudiv_step.sv | 33 +++
 rtl/bvudiv_seq.sv | 113 +++++++++++
 tb/tb_bvudiv_seq.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/bvudiv_pkg.sv
// Shared types and helpers for the bvudiv_seq restoring divider.
package bvudiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Width of a counter able to hold the values 0..w.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  // Low w bits set; saturates at 64 bits.
  function automatic logic [63:0] all_ones(input int w);
    if (w >= 64) return '1;
    return (64'(1) << w) - 64'(1);
  endfunction

endpackage

// File: rtl/bvudiv_step.sv
// One restoring radix-2 division step (combinational).
// The partial remainder is shifted left taking in_bit, then a trial
// subtraction of the divisor decides the quotient bit.
module bvudiv_step
  import bvudiv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W:0]   rem_i,
  input  logic         bit_i,
  input  logic [W-1:0] div_i,
  output logic [W:0]   rem_o,
  output logic         q_o
);

  logic [W:0] shifted;
  logic [W:0] diff;

  // The partial remainder stays below the divisor, so after the shift it
  // fits in W+1 bits and the MSB of the W+1-bit difference is the borrow.
  always_comb begin
    shifted = {rem_i[W-1:0], bit_i};
    diff    = shifted - {1'b0, div_i};
    if (!diff[W]) begin
      rem_o = diff;
      q_o   = 1'b1;
    end else begin
      rem_o = shifted;
      q_o   = 1'b0;
    end
  end

endmodule

// File: rtl/bvudiv_seq.sv
// Sequential unsigned divider with SMT-LIB bvudiv/bvurem semantics.
// Divide by zero yields quotient all ones and remainder equal to the dividend.
// Optional macro BVUDIV_ZERO_FASTPATH_EN: a zero divisor skips the W steps
// and goes straight from IDLE to DONE on the acceptance edge.
module bvudiv_seq
  import bvudiv_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         div_by_zero
);

  localparam int             CW   = cnt_w(W);
  localparam logic [CW-1:0]  LAST = CW'(W - 1);
`ifdef BVUDIV_ZERO_FASTPATH_EN
  localparam logic [63:0]    ONES64 = all_ones(W);
  localparam logic [W-1:0]   ONES   = ONES64[W-1:0];
`endif

  state_e        state_q, state_d;
  // Shift register: dividend bits leave at the MSB, quotient bits enter at the LSB.
  logic [W-1:0]  sr_q, sr_d;
  logic [W-1:0]  dv_q, dv_d;
  logic [W:0]    rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic [W:0]    step_rem;
  logic          step_qbit;

  bvudiv_step #(.W(W)) u_step (
    .rem_i (rem_q),
    .bit_i (sr_q[W-1]),
    .div_i (dv_q),
    .rem_o (step_rem),
    .q_o   (step_qbit)
  );

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      dv_q    <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      dv_q    <= dv_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state and datapath update for accept / step / hand-off.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    dv_d    = dv_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = dividend;
          dv_d    = divisor;
          rem_d   = '0;
          cnt_d   = '0;
          dbz_d   = (divisor == '0);
          state_d = BUSY;
`ifdef BVUDIV_ZERO_FASTPATH_EN
          if (divisor == '0) begin
            sr_d    = ONES;
            rem_d   = {1'b0, dividend};
            state_d = DONE;
          end
`endif
        end
      end
      BUSY: begin
        rem_d = step_rem;
        sr_d  = {sr_q[W-2:0], step_qbit};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = sr_q;
  assign remainder   = rem_q[W-1:0];
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_bvudiv_seq.sv
// Directed bench for bvudiv_seq at W=4.
module tb_bvudiv_seq;

  localparam int W = 4;
`ifdef BVUDIV_ZERO_FASTPATH_EN
  localparam int ZLAT = 0;
`else
  localparam int ZLAT = W;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  bvudiv_seq #(.W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drives one operation; lat counts clock edges after acceptance until
  // out_valid is seen (-1 on timeout). Operand inputs are scrambled after
  // acceptance. out_ready is held low for 'hold' cycles before taking it.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] d, input int hold,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 30) begin
      @(posedge clk); #1; guard++;
    end
    dividend = x; divisor = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = ~x; divisor = d + 4'd1;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = -1;
    q = quotient; r = remainder; z = div_by_zero;
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (quotient !== 4'd0) begin n_err++; $display("FAIL reset_quotient: got %0d expected 0", quotient); end
    n_cmp++; if (remainder !== 4'd0) begin n_err++; $display("FAIL reset_remainder: got %0d expected 0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
  endtask

  task automatic test_basic();
    int guard;
    int lat;
    dividend = 4'd13; divisor = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = 4'd0; divisor = 4'd0;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL basic_in_ready_busy: got %b expected 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (lat !== W) begin n_err++; $display("FAIL basic_latency: got %0d expected %0d", lat, W); end
    n_cmp++; if (quotient !== 4'd4) begin n_err++; $display("FAIL basic_q: got %0d expected 4", quotient); end
    n_cmp++; if (remainder !== 4'd1) begin n_err++; $display("FAIL basic_r: got %0d expected 1", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL basic_dbz: got %b expected 0", div_by_zero); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    guard = 0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL basic_in_ready_after: got %b expected 1", in_ready); end
  endtask

  task automatic test_zero();
    logic [W-1:0] q, r;
    logic z;
    int lat;
    run_op(4'd15, 4'd0, 0, q, r, z, lat);
    n_cmp++; if (q !== 4'd15) begin n_err++; $display("FAIL zero_q: got %0d expected 15", q); end
    n_cmp++; if (r !== 4'd15) begin n_err++; $display("FAIL zero_r: got %0d expected 15", r); end
    n_cmp++; if (z !== 1'b1) begin n_err++; $display("FAIL zero_dbz: got %b expected 1", z); end
    n_cmp++; if (lat !== ZLAT) begin n_err++; $display("FAIL zero_latency: got %0d expected %0d", lat, ZLAT); end
  endtask

  task automatic test_edges();
    logic [W-1:0] xs [4];
    logic [W-1:0] ds [4];
    logic [W-1:0] eq [4];
    logic [W-1:0] er [4];
    logic [W-1:0] q, r;
    logic z;
    int lat;
    xs = '{4'd0, 4'd7, 4'd15, 4'd2};
    ds = '{4'd5, 4'd7, 4'd1,  4'd9};
    eq = '{4'd0, 4'd1, 4'd15, 4'd0};
    er = '{4'd0, 4'd0, 4'd0,  4'd2};
    for (int i = 0; i < 4; i++) begin
      run_op(xs[i], ds[i], 1, q, r, z, lat);
      n_cmp++; if (q !== eq[i]) begin n_err++; $display("FAIL edge_q x=%0d d=%0d: got %0d expected %0d", xs[i], ds[i], q, eq[i]); end
      n_cmp++; if (r !== er[i]) begin n_err++; $display("FAIL edge_r x=%0d d=%0d: got %0d expected %0d", xs[i], ds[i], r, er[i]); end
      n_cmp++; if (z !== 1'b0) begin n_err++; $display("FAIL edge_dbz x=%0d d=%0d: got %b expected 0", xs[i], ds[i], z); end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    dividend = 4'd9; divisor = 4'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid_start: got %b expected 1", out_valid); end
    // New operands offered while the result is held must be ignored.
    in_valid = 1'b1; dividend = 4'd1; divisor = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid cyc%0d: got %b expected 1", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc%0d: got %b expected 0", i, in_ready); end
      n_cmp++; if (quotient !== 4'd4) begin n_err++; $display("FAIL bp_q cyc%0d: got %0d expected 4", i, quotient); end
      n_cmp++; if (remainder !== 4'd1) begin n_err++; $display("FAIL bp_r cyc%0d: got %0d expected 1", i, remainder); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_after: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_out_valid_after: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] q, r;
    logic z;
    int lat;
    logic seen;
    dividend = 4'd13; divisor = 4'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
    n_cmp++; if (quotient !== 4'd0) begin n_err++; $display("FAIL midrst_q: got %0d expected 0", quotient); end
    n_cmp++; if (remainder !== 4'd0) begin n_err++; $display("FAIL midrst_r: got %0d expected 0", remainder); end
    n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL midrst_dbz: got %b expected 0", div_by_zero); end
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL midrst_no_pulse: got %b expected 0", seen); end
    run_op(4'd6, 4'd4, 0, q, r, z, lat);
    n_cmp++; if (q !== 4'd1) begin n_err++; $display("FAIL midrst_next_q: got %0d expected 1", q); end
    n_cmp++; if (r !== 4'd2) begin n_err++; $display("FAIL midrst_next_r: got %0d expected 2", r); end
  endtask

  task automatic test_sweep();
    logic [W-1:0] q, r, eq, er;
    logic z, ez;
    int lat, elat;
    for (int x = 0; x < 16; x++) begin
      for (int d = 0; d < 16; d++) begin
        if (d == 0) begin
          eq = 4'd15; er = 4'(x); ez = 1'b1; elat = ZLAT;
        end else begin
          eq = 4'(x / d); er = 4'(x % d); ez = 1'b0; elat = W;
        end
        run_op(4'(x), 4'(d), int'($urandom_range(0, 2)), q, r, z, lat);
        n_cmp++; if (q !== eq) begin n_err++; $display("FAIL sweep_q x=%0d d=%0d: got %0d expected %0d", x, d, q, eq); end
        n_cmp++; if (r !== er) begin n_err++; $display("FAIL sweep_r x=%0d d=%0d: got %0d expected %0d", x, d, r, er); end
        n_cmp++; if (z !== ez) begin n_err++; $display("FAIL sweep_dbz x=%0d d=%0d: got %b expected %b", x, d, z, ez); end
        n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL sweep_lat x=%0d d=%0d: got %0d expected %0d", x, d, lat, elat); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_edges();
    test_backpressure();
    test_reset_mid();
    test_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
